// File: rtl/drac_reset_sequencer.sv
// drac_reset_sequencer
//   Tile reset sequencer. Synchronises the board reset (reset_l) into spc_grst_l,
//   waits for a wake-up counter to reach its MSB, and then releases NUM_DOMAINS
//   reset domains in index order. The domains are spaced STAGGER cycles apart.
//   A soft reset drains outstanding memory traffic, with a timeout. It then holds
//   every domain in reset for HOLD_CYCLES cycles and re-runs the staggered
//   release. The wake counter is not re-run for a soft reset.
module drac_reset_sequencer #(
  parameter int NUM_DOMAINS     = 3,
  parameter int WAKE_CNT_W      = 16,
  parameter int STAGGER         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 8,
  parameter int DRAIN_TIMEOUT_W = 12
) (
  input  logic                   clk_i,
  input  logic                   reset_l,
  output logic                   spc_grst_l,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  input  logic                   soft_rst_req_i,
  output logic                   soft_rst_ack_o,
  output logic                   drain_req_o,
  input  logic                   drain_idle_i,
  output logic                   timeout_o,
  output logic [2:0]             seq_state_o
);

  typedef enum logic [2:0] {
    ST_WAKE    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLD    = 3'd4
  } seq_state_e;

  localparam int STG_W  = (STAGGER > 1)     ? $clog2(STAGGER)     : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DOM_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DOM_W-1:0]  DOM_LAST  = DOM_W'(NUM_DOMAINS - 1);

  // Synchroniser chain for the deassertion of reset_l.
  logic [SYNC_STAGES-1:0] sync_q;

  // Sequencer state.
  seq_state_e                 state_q, state_d;
  logic [WAKE_CNT_W-1:0]      wake_cnt_q, wake_cnt_d;
  logic [STG_W-1:0]           stg_cnt_q, stg_cnt_d;
  logic [DOM_W-1:0]           dom_q, dom_d;       // next domain to release
  logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [DRAIN_TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic [NUM_DOMAINS-1:0]     rst_n_q, rst_n_d;
  logic                       drain_req_q, drain_req_d;
  logic                       ack_q, ack_d;
  logic                       timeout_q, timeout_d;
  logic                       pending_q, pending_d;  // soft request seen before RUN
  logic                       soft_seq_q, soft_seq_d; // current release follows a soft reset

  // Internal events that several states share.
  logic start_release;
  logic enter_run;
  logic enter_hold;

  // Reset assertion is asynchronous. Deassertion ripples through SYNC_STAGES flops.
  // NOTE: sequential state uses non-blocking assignments only. This keeps the
  // shift chain from collapsing into a single flop and avoids races with
  // readers in other processes.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign spc_grst_l = sync_q[SYNC_STAGES-1];

  // State register. Every flop returns to its reset value at once when reset_l drops.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_WAKE;
      wake_cnt_q  <= '0;
      stg_cnt_q   <= '0;
      dom_q       <= '0;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      rst_n_q     <= '0;
      drain_req_q <= 1'b0;
      ack_q       <= 1'b0;
      timeout_q   <= 1'b0;
      pending_q   <= 1'b0;
      soft_seq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      stg_cnt_q   <= stg_cnt_d;
      dom_q       <= dom_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rst_n_q     <= rst_n_d;
      drain_req_q <= drain_req_d;
      ack_q       <= ack_d;
      timeout_q   <= timeout_d;
      pending_q   <= pending_d;
      soft_seq_q  <= soft_seq_d;
    end
  end

  // Next-state logic and registered outputs for the sequencer.
  // NOTE: every variable gets a default before the case statement. A path
  // that left one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    wake_cnt_d    = wake_cnt_q;
    stg_cnt_d     = stg_cnt_q;
    dom_d         = dom_q;
    hold_cnt_d    = hold_cnt_q;
    to_cnt_d      = to_cnt_q;
    rst_n_d       = rst_n_q;
    drain_req_d   = 1'b0;
    ack_d         = 1'b0;
    timeout_d     = timeout_q;
    pending_d     = pending_q;
    soft_seq_d    = soft_seq_q;
    start_release = 1'b0;
    enter_run     = 1'b0;
    enter_hold    = 1'b0;

    unique case (state_q)
      ST_WAKE: begin
        if (soft_rst_req_i) pending_d = 1'b1;
        // The counter saturates at its MSB. Release starts on the edge that sets the MSB.
        if (spc_grst_l && !wake_cnt_q[WAKE_CNT_W-1]) begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
        if (wake_cnt_d[WAKE_CNT_W-1]) start_release = 1'b1;
      end

      ST_RELEASE: begin
        if (soft_rst_req_i) pending_d = 1'b1;
        if (stg_cnt_q == STG_LAST) begin
          stg_cnt_d      = '0;
          rst_n_d[dom_q] = 1'b1;
          dom_d          = dom_q + 1'b1;
          if (dom_q == DOM_LAST) enter_run = 1'b1;
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (soft_rst_req_i || pending_q) begin
          state_d     = ST_DRAIN;
          drain_req_d = 1'b1;
          to_cnt_d    = '0;
          pending_d   = 1'b0;
          soft_seq_d  = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Idle takes priority over a timeout that expires in the same cycle.
        if (drain_idle_i) begin
          timeout_d  = 1'b0;
          enter_hold = 1'b1;
        end else if (to_cnt_q == '1) begin
          timeout_d  = 1'b1;
          enter_hold = 1'b1;
        end else begin
          to_cnt_d    = to_cnt_q + 1'b1;
          drain_req_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) start_release = 1'b1;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end

      default: state_d = ST_WAKE;
    endcase

    // All domains drop on the same edge that drain_req_o drops.
    if (enter_hold) begin
      state_d    = ST_HOLD;
      rst_n_d    = '0;
      hold_cnt_d = '0;
    end

    // Domain 0 is released on the edge that enters RELEASE.
    if (start_release) begin
      rst_n_d    = '0;
      rst_n_d[0] = 1'b1;
      dom_d      = DOM_W'(1);
      stg_cnt_d  = '0;
      if (NUM_DOMAINS == 1) enter_run = 1'b1;
      else                  state_d   = ST_RELEASE;
    end

    // Completing a soft-reset sequence acknowledges it once.
    if (enter_run) begin
      state_d    = ST_RUN;
      ack_d      = soft_seq_q;
      soft_seq_d = 1'b0;
    end
  end

  assign rst_n_o        = rst_n_q;
  assign drain_req_o    = drain_req_q;
  assign soft_rst_ack_o = ack_q;
  assign timeout_o      = timeout_q;
  assign seq_state_o    = state_q;

endmodule

// File: tb/tb_drac_reset_sequencer.sv
// tb_drac_reset_sequencer
//   Directed bench for drac_reset_sequencer, using small test parameters.
//   Each stimulus step queues the output snapshot it expects for a given cycle.
//   A snapshot holds {spc_grst_l, rst_n_o, seq_state_o, drain_req_o,
//   soft_rst_ack_o, timeout_o}. After each rising edge the bench pops every due
//   snapshot and compares it with the outputs.
module tb_drac_reset_sequencer;

  localparam logic [2:0] WAKE = 3'd0, REL = 3'd1, RUN = 3'd2, DRN = 3'd3, HLD = 3'd4;

  logic       clk_i = 1'b0;
  logic       reset_l = 1'b0;
  logic       spc_grst_l;
  logic [2:0] rst_n_o;
  logic       soft_rst_req_i = 1'b0;
  logic       soft_rst_ack_o;
  logic       drain_req_o;
  logic       drain_idle_i = 1'b0;
  logic       timeout_o;
  logic [2:0] seq_state_o;

  drac_reset_sequencer #(
    .NUM_DOMAINS(3), .WAKE_CNT_W(4), .STAGGER(2),
    .SYNC_STAGES(2), .HOLD_CYCLES(4), .DRAIN_TIMEOUT_W(4)
  ) dut (
    .clk_i(clk_i), .reset_l(reset_l), .spc_grst_l(spc_grst_l), .rst_n_o(rst_n_o),
    .soft_rst_req_i(soft_rst_req_i), .soft_rst_ack_o(soft_rst_ack_o),
    .drain_req_o(drain_req_o), .drain_idle_i(drain_idle_i),
    .timeout_o(timeout_o), .seq_state_o(seq_state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    int         at;
    logic [9:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   base;

  wire [9:0] obs = {spc_grst_l, rst_n_o, seq_state_o, drain_req_o, soft_rst_ack_o, timeout_o};

  function automatic logic [9:0] snap(input logic spc, input logic [2:0] rst, input logic [2:0] st,
                                      input logic drn, input logic ack, input logic to);
    return {spc, rst, st, drn, ack, to};
  endfunction

  task automatic expect_span(input string tag, input int from, input int upto, input logic [9:0] e);
    for (int i = from; i <= upto; i++) sb_q.push_back('{tag, i, e});
  endtask

  task automatic check_due();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      n_run++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    check_due();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset state while reset_l is low.
    expect_span("reset", 0, 5, snap(0, 3'b000, WAKE, 0, 0, 0));
    check_due();
    repeat (5) step();

    // 1: power-up. spc_grst_l rises 2 edges after reset_l; release 8 cycles later; 0/+2/+4.
    reset_l = 1'b1;
    base = cyc;
    expect_span("pu_sync", base + 1,  base + 1,  snap(0, 3'b000, WAKE, 0, 0, 0));
    expect_span("pu_wake", base + 2,  base + 9,  snap(1, 3'b000, WAKE, 0, 0, 0));
    expect_span("pu_rel0", base + 10, base + 11, snap(1, 3'b001, REL,  0, 0, 0));
    expect_span("pu_rel1", base + 12, base + 13, snap(1, 3'b011, REL,  0, 0, 0));
    expect_span("pu_run",  base + 14, base + 16, snap(1, 3'b111, RUN,  0, 0, 0));
    repeat (16) step();

    // 2: soft reset, drain idle after 3 cycles.
    base = cyc;
    soft_rst_req_i = 1'b1;
    expect_span("sr_drain", base + 1,  base + 3,  snap(1, 3'b111, DRN, 1, 0, 0));
    expect_span("sr_hold",  base + 4,  base + 7,  snap(1, 3'b000, HLD, 0, 0, 0));
    expect_span("sr_rel0",  base + 8,  base + 9,  snap(1, 3'b001, REL, 0, 0, 0));
    expect_span("sr_rel1",  base + 10, base + 11, snap(1, 3'b011, REL, 0, 0, 0));
    expect_span("sr_ack",   base + 12, base + 12, snap(1, 3'b111, RUN, 0, 1, 0));
    expect_span("sr_run",   base + 13, base + 14, snap(1, 3'b111, RUN, 0, 0, 0));
    step();
    soft_rst_req_i = 1'b0;
    repeat (2) step();
    drain_idle_i = 1'b1;
    step();
    drain_idle_i = 1'b0;
    repeat (10) step();

    // 6: idle rises on the 16th DRAIN cycle. Idle wins and timeout stays 0.
    base = cyc;
    soft_rst_req_i = 1'b1;
    expect_span("tie_drain", base + 1,  base + 16, snap(1, 3'b111, DRN, 1, 0, 0));
    expect_span("tie_hold",  base + 17, base + 20, snap(1, 3'b000, HLD, 0, 0, 0));
    expect_span("tie_rel0",  base + 21, base + 22, snap(1, 3'b001, REL, 0, 0, 0));
    expect_span("tie_rel1",  base + 23, base + 24, snap(1, 3'b011, REL, 0, 0, 0));
    expect_span("tie_ack",   base + 25, base + 25, snap(1, 3'b111, RUN, 0, 1, 0));
    expect_span("tie_run",   base + 26, base + 26, snap(1, 3'b111, RUN, 0, 0, 0));
    step();
    soft_rst_req_i = 1'b0;
    repeat (15) step();
    drain_idle_i = 1'b1;
    step();
    drain_idle_i = 1'b0;
    repeat (9) step();

    // 3: drain timeout. HOLD after 16 DRAIN cycles; timeout_o stays set in RUN.
    base = cyc;
    soft_rst_req_i = 1'b1;
    expect_span("to_drain", base + 1,  base + 16, snap(1, 3'b111, DRN, 1, 0, 0));
    expect_span("to_hold",  base + 17, base + 20, snap(1, 3'b000, HLD, 0, 0, 1));
    expect_span("to_rel0",  base + 21, base + 22, snap(1, 3'b001, REL, 0, 0, 1));
    expect_span("to_rel1",  base + 23, base + 24, snap(1, 3'b011, REL, 0, 0, 1));
    expect_span("to_ack",   base + 25, base + 25, snap(1, 3'b111, RUN, 0, 1, 1));
    expect_span("to_run",   base + 26, base + 28, snap(1, 3'b111, RUN, 0, 0, 1));
    step();
    soft_rst_req_i = 1'b0;
    repeat (27) step();

    // 5: reset_l low mid-DRAIN clears everything immediately.
    base = cyc;
    soft_rst_req_i = 1'b1;
    expect_span("rd_drain", base + 1, base + 3, snap(1, 3'b111, DRN, 1, 0, 1));
    step();
    soft_rst_req_i = 1'b0;
    repeat (2) step();
    reset_l = 1'b0;
    #1;
    expect_span("rd_async", cyc, cyc, snap(0, 3'b000, WAKE, 0, 0, 0));
    check_due();
    expect_span("rd_held", cyc + 1, cyc + 3, snap(0, 3'b000, WAKE, 0, 0, 0));
    repeat (3) step();

    // Full wake after reset, with 4: a request in RELEASE plus a second one in DRAIN.
    reset_l = 1'b1;
    base = cyc;
    expect_span("pp_sync",  base + 1,  base + 1,  snap(0, 3'b000, WAKE, 0, 0, 0));
    expect_span("pp_wake",  base + 2,  base + 9,  snap(1, 3'b000, WAKE, 0, 0, 0));
    expect_span("pp_rel0",  base + 10, base + 11, snap(1, 3'b001, REL,  0, 0, 0));
    expect_span("pp_rel1",  base + 12, base + 13, snap(1, 3'b011, REL,  0, 0, 0));
    expect_span("pp_run",   base + 14, base + 14, snap(1, 3'b111, RUN,  0, 0, 0));
    expect_span("pp_drain", base + 15, base + 17, snap(1, 3'b111, DRN,  1, 0, 0));
    expect_span("pp_hold",  base + 18, base + 21, snap(1, 3'b000, HLD,  0, 0, 0));
    expect_span("pp_rel2",  base + 22, base + 23, snap(1, 3'b001, REL,  0, 0, 0));
    expect_span("pp_rel3",  base + 24, base + 25, snap(1, 3'b011, REL,  0, 0, 0));
    expect_span("pp_ack",   base + 26, base + 26, snap(1, 3'b111, RUN,  0, 1, 0));
    expect_span("pp_once",  base + 27, base + 34, snap(1, 3'b111, RUN,  0, 0, 0));
    repeat (11) step();
    soft_rst_req_i = 1'b1;
    step();
    soft_rst_req_i = 1'b0;
    repeat (4) step();
    soft_rst_req_i = 1'b1;
    step();
    soft_rst_req_i = 1'b0;
    drain_idle_i = 1'b1;
    step();
    drain_idle_i = 1'b0;
    repeat (16) step();

    // Every queued expectation must have been consumed.
    n_run++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
